// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder taking two information bits per cycle and
// emitting radix-4 codewords, with a zero-tail flush returning the state to 0.
module conv_encoder #(
    parameter int                    CONSTR_LEN = 9,
    parameter logic [CONSTR_LEN-1:0] G0         = 9'o561,
    parameter logic [CONSTR_LEN-1:0] G1         = 9'o753,
    parameter int                    FRAME_LEN  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_enc,
    input  logic       i_start,
    input  logic [1:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [3:0] o_code,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_tail,
    output logic       o_busy,
    output logic       o_done
);
    localparam int SR_W   = CONSTR_LEN - 1;
    localparam int PAIRS  = FRAME_LEN / 2;
    localparam int CNT_W  = $clog2(PAIRS + 1);
    localparam int NTAIL  = (CONSTR_LEN - 1) / 2;
    localparam int TAIL_W = $clog2(NTAIL + 1);

    localparam logic [CNT_W-1:0]  LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam logic [TAIL_W-1:0] TAIL_END  = TAIL_W'(NTAIL);

    typedef enum logic [1:0] {IDLE, ENCODE, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [SR_W-1:0]   sr, sr_nxt, sr_mid, sr_pair;
    logic [CNT_W-1:0]  pair_cnt, pair_cnt_nxt;
    logic [TAIL_W-1:0] tail_cnt, tail_cnt_nxt;
    logic [3:0]        code_nxt, code_pair;
    logic [1:0]        pair_bits;
    logic              valid_nxt, tail_nxt, done_nxt;
    logic              slot_free, in_xfer, out_xfer, tail_emit, load, last_tail_xfer;

    function automatic logic [1:0] enc_bit(input logic [CONSTR_LEN-1:0] v);
        return {^(v & G0), ^(v & G1)};
    endfunction

    // The later bit of the pair sees the register already shifted by the earlier bit.
    always_comb begin
        pair_bits = (state == FLUSH) ? 2'b00 : i_data;
        sr_mid    = {pair_bits[1], sr[SR_W-1:1]};
        sr_pair   = {pair_bits[0], sr_mid[SR_W-1:1]};
        code_pair = {enc_bit({pair_bits[1], sr}), enc_bit({pair_bits[0], sr_mid})};
    end

    assign slot_free      = !o_valid || i_ready;
    assign o_ready        = (state == ENCODE) && en_enc && slot_free;
    assign in_xfer        = i_valid && o_ready;
    assign out_xfer       = o_valid && i_ready;
    assign tail_emit      = (state == FLUSH) && en_enc && slot_free && (tail_cnt != TAIL_END);
    assign load           = in_xfer || tail_emit;
    // Draining the final tail ends the frame even with the encoder disabled.
    assign last_tail_xfer = (state == FLUSH) && (tail_cnt == TAIL_END) && out_xfer;
    assign o_busy         = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        pair_cnt_nxt = pair_cnt;
        tail_cnt_nxt = tail_cnt;
        code_nxt     = o_code;
        valid_nxt    = o_valid;
        tail_nxt     = o_tail;
        done_nxt     = 1'b0;

        if (out_xfer) begin
            valid_nxt = 1'b0;
            tail_nxt  = 1'b0;
        end
        if (load) begin
            code_nxt  = code_pair;
            valid_nxt = 1'b1;
            tail_nxt  = (state == FLUSH);
            sr_nxt    = sr_pair;
        end

        case (state)
            IDLE: begin
                if (en_enc && i_start) begin
                    sr_nxt       = '0;
                    pair_cnt_nxt = '0;
                    tail_cnt_nxt = '0;
                    state_nxt    = ENCODE;
                end
            end
            ENCODE: begin
                if (in_xfer) begin
                    pair_cnt_nxt = pair_cnt + CNT_W'(1);
                    if (pair_cnt == LAST_PAIR) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (tail_emit) tail_cnt_nxt = tail_cnt + TAIL_W'(1);
                if (last_tail_xfer) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            pair_cnt <= '0;
            tail_cnt <= '0;
            o_code   <= 4'b0000;
            o_valid  <= 1'b0;
            o_tail   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            pair_cnt <= pair_cnt_nxt;
            tail_cnt <= tail_cnt_nxt;
            o_code   <= code_nxt;
            o_valid  <= valid_nxt;
            o_tail   <= tail_nxt;
            o_done   <= done_nxt;
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: directed frames plus randomized frames with random
// valid/ready/enable, checked against a tap-sum model of the code.
module tb_conv_encoder;
    localparam int K     = 9;
    localparam int FL    = 4;
    localparam int PAIRS = FL / 2;
    localparam int NTAIL = (K - 1) / 2;
    localparam int NCW   = PAIRS + NTAIL;
    localparam logic [K-1:0] GEN0 = 9'o561;
    localparam logic [K-1:0] GEN1 = 9'o753;

    logic       clk = 1'b0;
    logic       rst, en_enc, i_start, i_valid, i_ready;
    logic [1:0] i_data;
    logic       o_ready, o_valid, o_tail, o_busy, o_done;
    logic [3:0] o_code;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] pairs  [PAIRS];
    logic [3:0] exp_cw [NCW];
    logic [3:0] first_code;
    logic       first_tail;
    int         first_lat;

    always #5 clk = ~clk;

    conv_encoder #(.CONSTR_LEN(K), .G0(GEN0), .G1(GEN1), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .en_enc(en_enc), .i_start(i_start),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_code(o_code), .o_valid(o_valid), .i_ready(i_ready),
        .o_tail(o_tail), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Code bit at time n is the parity of G taps over u[n], u[n-1], ... u[n-K+1].
    task automatic build_expected();
        bit u [2*NCW];
        for (int p = 0; p < NCW; p++) begin
            u[2*p]   = (p < PAIRS) ? pairs[p][1] : 1'b0;
            u[2*p+1] = (p < PAIRS) ? pairs[p][0] : 1'b0;
        end
        for (int p = 0; p < NCW; p++) begin
            logic [3:0] cw;
            cw = 4'b0000;
            for (int h = 0; h < 2; h++) begin
                int n;
                bit c0, c1;
                n = 2*p + h;
                c0 = 1'b0;
                c1 = 1'b0;
                for (int j = 0; j < K; j++)
                    if (n - j >= 0) begin
                        c0 = c0 ^ (GEN0[K-1-j] & u[n-j]);
                        c1 = c1 ^ (GEN1[K-1-j] & u[n-j]);
                    end
                cw[3-2*h] = c0;
                cw[2-2*h] = c1;
            end
            exp_cw[p] = cw;
        end
    endtask

    task automatic run_frame(input int rdy_pct, input int vld_pct, input int en_pct,
                             input int abort_at, input bit stall3);
        int pidx = 0, oidx = 0, cyc = 0, in_cyc = -1, stall_cnt = 0;
        bit got_first = 0, stall = 0, held_tail = 0;
        logic [3:0] held = 4'b0;
        build_expected();
        en_enc = 1'b1; i_start = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        while (1) begin
            en_enc  = ($urandom_range(99) < en_pct);
            i_ready = ($urandom_range(99) < rdy_pct);
            if (stall3 && oidx == 1 && stall_cnt < 3) begin
                i_ready = 1'b0;
                stall_cnt++;
            end
            i_valid = ($urandom_range(99) < vld_pct);
            i_data  = (pidx < PAIRS) ? pairs[pidx] : 2'($urandom);
            @(negedge clk);
            cyc++;
            check("no_early_done", o_done, 0);
            if (pidx >= PAIRS) check("ready_after_data", o_ready, 0);
            if (o_valid && !i_ready) check("ready_in_stall", o_ready, 0);
            if (stall) begin
                check("stall_code", o_code, held);
                check("stall_tail", o_tail, held_tail);
                check("stall_valid", o_valid, 1);
            end
            stall = o_valid && !i_ready;
            held = o_code;
            held_tail = o_tail;
            if (o_valid && !got_first) begin
                got_first  = 1;
                first_code = o_code;
                first_tail = o_tail;
                first_lat  = cyc - in_cyc;
            end
            if (i_valid && o_ready) begin
                if (in_cyc < 0) in_cyc = cyc;
                pidx++;
            end
            if (o_valid && i_ready) begin
                check("code", o_code, exp_cw[oidx]);
                check("tail", o_tail, (oidx >= PAIRS));
                oidx++;
            end
            @(posedge clk); #1;
            if (abort_at >= 0 && oidx >= abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_outputs", {o_code, o_valid, o_tail, o_ready, o_busy, o_done}, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                i_valid = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("no_done_after_abort", o_done, 0);
                    check("idle_after_abort", o_busy, 0);
                end
                @(posedge clk); #1;
                return;
            end
            if (oidx == NCW) break;
            if (cyc > 400) begin
                check("frame_timeout", oidx, NCW);
                break;
            end
        end
        check("done_pulse", o_done, 1);
        check("busy_end", o_busy, 0);
        i_valid = 1'b0;
        @(posedge clk); #1;
        check("done_once", o_done, 0);
    endtask

    initial begin
        rst = 1'b1; en_enc = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = 2'b00;
        #1;
        check("reset_outputs", {o_code, o_valid, o_tail, o_ready, o_busy, o_done}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        en_enc = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", o_ready, 0);
            check("idle_busy", o_busy, 0);
            check("idle_valid", o_valid, 0);
        end
        @(posedge clk); #1;

        pairs[0] = 2'b10; pairs[1] = 2'($urandom);
        run_frame(100, 100, 100, -1, 0);
        check("first_code_10", first_code, 4'b1101);
        check("first_tail_10", first_tail, 0);
        check("first_latency", first_lat, 1);

        pairs[0] = 2'b11; pairs[1] = 2'($urandom);
        run_frame(100, 100, 100, -1, 0);
        check("first_code_11", first_code, 4'b1110);

        pairs[0] = 2'b00; pairs[1] = 2'b00;
        run_frame(100, 100, 100, -1, 0);

        pairs[0] = 2'($urandom); pairs[1] = 2'($urandom);
        run_frame(100, 100, 100, -1, 1);

        pairs[0] = 2'($urandom); pairs[1] = 2'($urandom);
        run_frame(100, 100, 100, PAIRS + 1, 0);
        pairs[0] = 2'b10; pairs[1] = 2'($urandom);
        run_frame(100, 100, 100, -1, 0);
        check("code_after_abort", first_code, 4'b1101);

        for (int f = 0; f < 40; f++) begin
            for (int p = 0; p < PAIRS; p++) pairs[p] = 2'($urandom);
            run_frame(60, 70, 85, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 The block SHALL have parameter CONSTR_LEN, default 9, the constraint length K; it SHALL be odd, 3..9, so that 2^(K-1) <= `MAX_STATE_NUM`.
REQ-002 The block SHALL have parameter G0, default 9'o561, the generator polynomial for code bit c0, K bits wide, with the MSB tapping the current input bit.
REQ-003 The block SHALL have parameter G1, default 9'o753, the generator polynomial for code bit c1, with the same bit convention as G0.
REQ-004 The block SHALL have parameter FRAME_LEN, default 64, the number of information bits per frame; it SHALL be even and >= 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port en_enc, input, 1 bit: encoder enable.
REQ-008 The block SHALL have port i_start, input, 1 bit: frame start request.
REQ-009 The block SHALL have port i_data, input, 2 bits: information pair; i_data[1] is earlier in time.
REQ-010 The block SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-011 The block SHALL have port o_ready, output, 1 bit: the encoder accepts i_data this cycle.
REQ-012 The block SHALL have port o_code, output, 4 bits: radix-4 codeword {c0,c1 of earlier bit, c0,c1 of later bit}.
REQ-013 The block SHALL have port o_valid, output, 1 bit: o_code is valid.
REQ-014 The block SHALL have port i_ready, input, 1 bit: downstream accepts o_code.
REQ-015 The block SHALL have port o_tail, output, 1 bit: o_code is a termination (flush) codeword.
REQ-016 The block SHALL have port o_busy, output, 1 bit: a frame is in progress.
REQ-017 The block SHALL have port o_done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-018 The FSM SHALL have states IDLE, ENCODE and FLUSH.
REQ-019 In IDLE with en_enc=1 and i_start=1, the block SHALL clear the (K-1)-bit shift register sr and the pair counter, then enter ENCODE.
REQ-020 i_start SHALL be ignored outside IDLE.
REQ-021 For each bit b, v = {b, sr}, with b at the MSB and sr[K-2] the most recent past bit.
REQ-022 For each bit b: c0 = XOR-reduce(v & G0) and c1 = XOR-reduce(v & G1).
REQ-023 After each bit b, sr SHALL update as sr <= {b, sr[K-2:1]}.
REQ-024 Within one cycle, i_data[1] SHALL be encoded first and i_data[0] second, using the sr updated by i_data[1].
REQ-025 o_ready SHALL equal (state==ENCODE) && en_enc && (!o_valid || i_ready).
REQ-026 An input transfer SHALL occur when i_valid && o_ready.
REQ-027 An output transfer SHALL occur when o_valid && i_ready.
REQ-028 On an input transfer, o_code SHALL be registered and o_valid=1 SHALL be asserted on the next cycle (latency 1); sr and the pair counter SHALL advance.
REQ-029 o_valid SHALL clear after an output transfer unless a new codeword loads in the same cycle.
REQ-030 While o_valid=1 && i_ready=0, o_code, o_tail and o_valid SHALL remain stable.
REQ-031 Output draining SHALL NOT depend on en_enc.
REQ-032 When en_enc=0, the block SHALL freeze the FSM, sr and the counters, and SHALL accept no input.
REQ-033 On the input transfer of pair FRAME_LEN/2, the FSM SHALL enter FLUSH.
REQ-034 In FLUSH, the block SHALL feed the data pair 2'b00 internally and emit one codeword with o_tail=1 whenever (!o_valid || i_ready) && en_enc, for exactly (K-1)/2 codewords; these return sr to 0.
REQ-035 The output transfer of the last tail codeword SHALL move the FSM to IDLE and pulse o_done for one cycle on the next cycle.
REQ-036 o_busy SHALL be 1 in ENCODE and in FLUSH, and SHALL be 1 until that last tail codeword transfers.
REQ-037 The pair counter SHALL be $clog2(FRAME_LEN/2+1) bits wide and SHALL NOT wrap within a frame.
REQ-038 When an input transfer and an output transfer occur in the same cycle, the new codeword SHALL replace the old one with no bubble.
REQ-039 i_valid received while the FSM is in IDLE or FLUSH SHALL NOT be consumed.

Reset
REQ-040 While rst=1, asynchronously: state=IDLE, sr=0, counters=0, o_code=4'b0000, o_valid=0, o_tail=0, o_ready=0, o_busy=0, o_done=0.
REQ-041 Reset mid-frame SHALL abort the frame with no o_done pulse; the pending codeword SHALL be discarded.

Verification
REQ-042 Assert rst mid-stream -> all outputs 0 within the same cycle, with no clock edge required.
REQ-043 Defaults; start; i_data=2'b10, i_valid=1, i_ready=1 -> next cycle o_code=4'b1101, o_valid=1, o_tail=0.
REQ-044 Defaults; fresh frame; i_data=2'b11 -> o_code=4'b1110.
REQ-045 FRAME_LEN=4, all-zero data, i_ready=1 -> 2 data codewords 4'b0000 (o_tail=0), then 4 tail codewords 4'b0000 (o_tail=1), o_done pulsed once the cycle after the 6th transfer, o_busy=0 after.
REQ-046 Hold i_ready=0 for 3 cycles mid-frame -> o_code stable, o_ready=0, no pair lost or duplicated; the sequence matches the reference model.
REQ-047 rst during FLUSH, then a new frame with 2'b10 -> no o_done; first codeword is 4'b1101, proving sr cleared.
